gate_bist_ctrl: RTL and testbench
=================================

Name: gate_bist_ctrl

Overview:
Built-in self-test sequencer for any 2-input gate primitive in the nands library (and, or, nand, xor, ...). On start, it drives all four input vectors onto the gate under test. After a settle delay it samples the gate output and compares it against a 4-bit expected truth table. It reports a per-vector fail mask and a pass flag. It sits beside each gate instance in the hardware regression harness and replaces hand-stepped stimulus.

Parameters:
SETTLE_CYCLES, 2, full clock cycles A_o/B_o are held stable before Y_i is sampled (legal range 0..255)
CNT_W, derived as $clog2(SETTLE_CYCLES+1) (minimum 1), settle counter width; localparam, not overridable

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  request a test run; sampled only in IDLE
abort_i  in  1  cancel a run in progress
truth_i  in  4  expected Y per vector; bit index = {A,B}; sampled when start is accepted
Y_i  in  1  output of gate under test
A_o  out  1  gate input A (registered)
B_o  out  1  gate input B (registered)
busy_o  out  1  high from the cycle after start acceptance until DONE is left
done_o  out  1  one-cycle pulse at run completion
pass_o  out  1  1 iff the last completed run had no mismatches; held
fail_mask_o  out  4  bit v set if the vector {A,B}=v mismatched; held

Behaviour:
- Reset (async assert, sync release): state IDLE. A_o, B_o, busy_o, done_o, pass_o = 0. fail_mask_o = 0. Vector index = 0. Settle counter = 0.
- States:
  - IDLE: on start_i && !abort_i, latch truth_i, clear fail_mask_o and pass_o, and set vector index v=0 with {A_o,B_o}=0. Go to SETTLE, or to CHECK if SETTLE_CYCLES=0.
  - SETTLE: counter counts 1..SETTLE_CYCLES; A_o/B_o stay constant. When the count reaches SETTLE_CYCLES, go to CHECK.
  - CHECK (1 cycle): compare Y_i with latched truth[v]; on mismatch set fail_mask_o[v].
    - If v<3: v++, drive {A_o,B_o}=v+1 at the same edge, reset the counter, and go to SETTLE (or CHECK if SETTLE_CYCLES=0).
    - If v=3: go to DONE.
  - DONE (1 cycle): done_o=1. pass_o = (final fail_mask == 0), including the v=3 result. A_o/B_o return to 0. Go to IDLE.
- Vector order: 00, 01, 10, 11.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. done_o is high in the cycle beginning 4*(SETTLE_CYCLES+1)+1 edges after the edge that accepted start (13 for the default).
- busy_o = 1 in SETTLE, CHECK and DONE.
- start_i while not in IDLE: ignored, with no queuing.
- start_i asserted continuously: a new run starts the cycle after DONE.
- abort_i in any non-IDLE state: next edge goes to IDLE. A_o/B_o = 0, fail_mask_o = 0, pass_o = 0, no done_o pulse. Abort in IDLE is a no-op. abort_i has priority over start_i.
- truth_i changes during a run have no effect.
- Y_i is sampled only in CHECK and is treated as synchronous; the harness guarantees settle via SETTLE_CYCLES.
- Reset asserted mid-run: immediate return to reset values; no done_o.

Decomposition:
- Package gate_bist_pkg:
  - state enum (IDLE, SETTLE, CHECK, DONE)
  - NUM_VECTORS=4
  - truth-table constants TT_AND=4'b1000, TT_NAND=4'b0111, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110
- No sub-module. The settle counter and FSM fit in one module (~150 lines).

Test Plan:
- AND gate DUT, truth_i=TT_AND, SETTLE_CYCLES=2, one-cycle start pulse -> A/B sequence 00,01,10,11 (3 cycles each), done_o at edge 13, pass_o=1, fail_mask_o=0000.
- AND gate DUT, truth_i=TT_NAND -> done_o at edge 13, fail_mask_o=1111, pass_o=0; next run with TT_AND clears the mask at start and ends pass_o=1.
- Y_i tied 0, truth_i=TT_OR -> fail_mask_o=1110, pass_o=0; tied 1 with TT_AND -> fail_mask_o=0111.
- abort_i pulsed during vector 2 SETTLE -> IDLE next edge, A_o=B_o=0, busy_o=0, fail_mask_o=0, pass_o=0, no done_o. start_i pulsed during a run -> ignored; exactly one done_o.
- rst_ni driven low mid-CHECK asynchronously -> all outputs 0 before the next clock edge; after release, the block idles until start.
- SETTLE_CYCLES=0 build, XOR DUT with TT_XOR -> one cycle per vector, done_o at edge 5, pass_o=1; held start_i -> back-to-back runs, done_o every 5 cycles.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared types and constants for the 2-input gate BIST sequencer.
//   state_e      - sequencer FSM states
//   NUM_VECTORS  - number of input vectors applied to a 2-input gate
//   TT_*         - expected truth tables, bit index = {A,B}
//   cnt_width()  - settle counter width for a given settle length (minimum 1)
package gate_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int NUM_VECTORS = 4;

    localparam logic [NUM_VECTORS-1:0] TT_AND  = 4'b1000;
    localparam logic [NUM_VECTORS-1:0] TT_NAND = 4'b0111;
    localparam logic [NUM_VECTORS-1:0] TT_OR   = 4'b1110;
    localparam logic [NUM_VECTORS-1:0] TT_NOR  = 4'b0001;
    localparam logic [NUM_VECTORS-1:0] TT_XOR  = 4'b0110;

    function automatic int cnt_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: BIST sequencer for a 2-input gate primitive.
// Applies {A,B} = 00,01,10,11, holds each vector SETTLE_CYCLES cycles, samples
// Y_i for one CHECK cycle, and reports a per-vector fail mask plus pass flag.
// Ports:
//   clk_i, rst_ni      clock (rising edge), async active-low reset
//   start_i            start a run (accepted in IDLE, and in DONE for back-to-back runs)
//   abort_i            cancel a run in progress; wins over start_i
//   truth_i[3:0]       expected Y per vector, latched at start
//   Y_i                gate-under-test output
//   A_o, B_o           registered gate inputs
//   busy_o             run in progress (SETTLE/CHECK/DONE)
//   done_o             one-cycle completion pulse
//   pass_o             last completed run had no mismatches (held)
//   fail_mask_o[3:0]   bit v set if vector v mismatched (held)
import gate_bist_pkg::*;

module gate_bist_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [NUM_VECTORS-1:0] truth_i,
    input  logic                   Y_i,
    output logic                   A_o,
    output logic                   B_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [NUM_VECTORS-1:0] fail_mask_o
);

    localparam int               CNT_W   = cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);
    localparam logic [1:0]       V_LAST  = 2'(NUM_VECTORS - 1);

    state_e                   state_q, state_d;
    logic [1:0]               v_q, v_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_VECTORS-1:0]   truth_q, truth_d;
    logic [NUM_VECTORS-1:0]   mask_q, mask_d;
    logic                     pass_q, pass_d;
    logic [CNT_W-1:0]         cnt_inc;
    state_e                   vec_entry;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // With no settle time each vector goes straight to its CHECK cycle.
    always_comb begin
        vec_entry = ST_SETTLE;
        if (SETTLE_CYCLES == 0) vec_entry = ST_CHECK;
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        truth_d = truth_q;
        mask_d  = mask_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = vec_entry;
                    truth_d = truth_i;
                    mask_d  = '0;
                    pass_d  = 1'b0;
                    v_d     = '0;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_MAX) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (Y_i != truth_q[v_q]) mask_d[v_q] = 1'b1;
                cnt_d = '0;
                if (v_q != V_LAST) begin
                    v_d     = v_q + 2'd1;
                    state_d = vec_entry;
                end else begin
                    // Vector index doubles as {A,B}; clearing it parks the gate inputs at 0.
                    v_d     = '0;
                    state_d = ST_DONE;
                    pass_d  = (mask_d == '0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                // A held start launches the next run straight out of DONE so runs
                // repeat with no idle gap.
                if (start_i) begin
                    state_d = vec_entry;
                    truth_d = truth_i;
                    mask_d  = '0;
                    pass_d  = 1'b0;
                    v_d     = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            v_d     = '0;
            cnt_d   = '0;
            mask_d  = '0;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            truth_q <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            truth_q <= truth_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
        end
    end

    assign A_o         = v_q[1];
    assign B_o         = v_q[0];
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign pass_o      = pass_q;
    assign fail_mask_o = mask_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: self-checking bench for gate_bist_ctrl.
// Two instances: SETTLE_CYCLES=2 (dut2) and SETTLE_CYCLES=0 (dut0), each driving
// a behavioural gate model. Edge numbering: the edge that accepts start is edge 1,
// so done_o is expected in the cycle after edge 1+4*(SETTLE_CYCLES+1).
import gate_bist_pkg::*;

module tb_gate_bist_ctrl;

    typedef enum int {G_AND, G_OR, G_XOR, G_TIE0, G_TIE1} gate_e;

    typedef struct {
        logic [3:0] mask;
        logic       pass;
        int         cyc;
    } exp_t;

    typedef struct {
        gate_e      g;
        logic [3:0] tt;
        logic [3:0] em;
        logic       ep;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       st2, ab2, st0, ab0;
    logic [3:0] tr2, tr0;
    logic       y2, y0;
    logic       a2, b2, busy2, done2, pass2;
    logic       a0, b0, busy0, done0, pass0;
    logic [3:0] m2, m0;
    gate_e      g2, g0;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   dcnt2 = 0;
    int   dcnt0 = 0;
    exp_t q2[$];
    exp_t q0[$];
    vec_t tbl[8];

    function automatic logic gate_y(input gate_e g, input logic a, input logic b);
        case (g)
            G_AND:   return a & b;
            G_OR:    return a | b;
            G_XOR:   return a ^ b;
            G_TIE0:  return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign y2 = gate_y(g2, a2, b2);
    assign y0 = gate_y(g0, a0, b0);

    gate_bist_ctrl #(.SETTLE_CYCLES(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st2), .abort_i(ab2), .truth_i(tr2), .Y_i(y2),
        .A_o(a2), .B_o(b2), .busy_o(busy2), .done_o(done2), .pass_o(pass2), .fail_mask_o(m2)
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st0), .abort_i(ab0), .truth_i(tr0), .Y_i(y0),
        .A_o(a0), .B_o(b0), .busy_o(busy0), .done_o(done0), .pass_o(pass0), .fail_mask_o(m0)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboards: each done_o pulse pops the oldest expected run result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done2 === 1'b1) begin
            dcnt2++;
            if (q2.size() == 0) chk("done2_unexpected", 1, 0);
            else begin
                e = q2.pop_front();
                chk("done2_cycle", cyc, e.cyc);
                chk("mask2_at_done", m2, e.mask);
                chk("pass2_at_done", pass2, e.pass);
                chk("busy2_in_done", busy2, 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done0 === 1'b1) begin
            dcnt0++;
            if (q0.size() == 0) chk("done0_unexpected", 1, 0);
            else begin
                e = q0.pop_front();
                chk("done0_cycle", cyc, e.cyc);
                chk("mask0_at_done", m0, e.mask);
                chk("pass0_at_done", pass0, e.pass);
            end
        end
    end

    // Called at a negedge; leaves the bench at the negedge after the accepting edge.
    task automatic run2(input gate_e g, input logic [3:0] tt, input logic [3:0] em,
                        input logic ep, input bit push);
        exp_t e;
        g2  = g;
        tr2 = tt;
        st2 = 1'b1;
        if (push) begin
            e.mask = em; e.pass = ep; e.cyc = cyc + 1 + 12;
            q2.push_back(e);
        end
        @(negedge clk);
        st2 = 1'b0;
        tr2 = ~tt;
        chk("busy2_after_start", busy2, 1);
        chk("mask2_cleared_at_start", m2, 0);
        chk("pass2_cleared_at_start", pass2, 0);
    endtask

    task automatic wait_q(input bit sel0, input int budget);
        int n = 0;
        while (((sel0 ? q0.size() : q2.size()) != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((sel0 ? q0.size() : q2.size()) != 0) begin
            chk(sel0 ? "done0_timeout" : "done2_timeout", 1, 0);
            if (sel0) q0.delete(); else q2.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   d;
        int   c;
        exp_t e;

        tbl[0] = '{G_AND,  TT_AND,  4'b0000, 1'b1};
        tbl[1] = '{G_AND,  TT_NAND, 4'b1111, 1'b0};
        tbl[2] = '{G_AND,  TT_AND,  4'b0000, 1'b1};
        tbl[3] = '{G_TIE0, TT_OR,   4'b1110, 1'b0};
        tbl[4] = '{G_TIE1, TT_AND,  4'b0111, 1'b0};
        tbl[5] = '{G_XOR,  TT_XOR,  4'b0000, 1'b1};
        tbl[6] = '{G_OR,   TT_OR,   4'b0000, 1'b1};
        tbl[7] = '{G_OR,   TT_XOR,  4'b1000, 1'b0};

        rst_n = 1'b0;
        st2 = 0; ab2 = 0; tr2 = 4'h0; g2 = G_AND;
        st0 = 0; ab0 = 0; tr0 = 4'h0; g0 = G_XOR;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_A2", a2, 0);       chk("rst_B2", b2, 0);
        chk("rst_busy2", busy2, 0); chk("rst_done2", done2, 0);
        chk("rst_pass2", pass2, 0); chk("rst_mask2", m2, 0);
        chk("rst_busy0", busy0, 0); chk("rst_mask0", m0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A/B vector sequence and done timing for a passing AND run
        g2 = G_AND; tr2 = TT_AND; st2 = 1'b1;
        e.mask = 4'b0000; e.pass = 1'b1; e.cyc = cyc + 13;
        q2.push_back(e);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            st2 = 1'b0;
            chk($sformatf("ab2_edge%0d", k), {a2, b2}, (k <= 12) ? (k - 1) / 3 : 0);
            chk($sformatf("busy2_edge%0d", k), busy2, 1);
        end
        wait_q(0, 40);
        chk("busy2_idle_after_run", busy2, 0);

        // Table-driven runs on the SETTLE_CYCLES=2 instance
        foreach (tbl[i]) begin
            run2(tbl[i].g, tbl[i].tt, tbl[i].em, tbl[i].ep, 1);
            wait_q(0, 40);
            chk($sformatf("mask2_held_%0d", i), m2, tbl[i].em);
            chk($sformatf("pass2_held_%0d", i), pass2, tbl[i].ep);
        end

        // Abort in IDLE is a no-op; abort beats start in IDLE
        ab2 = 1'b1;
        @(negedge clk);
        ab2 = 1'b0;
        chk("idle_abort_mask_held", m2, 4'b1000);
        ab2 = 1'b1; st2 = 1'b1;
        @(negedge clk);
        ab2 = 1'b0; st2 = 1'b0;
        chk("abort_beats_start", busy2, 0);
        chk("abort_beats_start_mask", m2, 4'b1000);

        // Abort during vector 2 SETTLE
        d = dcnt2;
        run2(G_AND, TT_NAND, 4'b0000, 1'b0, 0);
        repeat (6) @(negedge clk);
        chk("pre_abort_ab", {a2, b2}, 2'b10);
        chk("pre_abort_mask", m2, 4'b0011);
        ab2 = 1'b1;
        @(negedge clk);
        ab2 = 1'b0;
        chk("abort_ab", {a2, b2}, 0);
        chk("abort_busy", busy2, 0);
        chk("abort_mask", m2, 0);
        chk("abort_pass", pass2, 0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", dcnt2 - d, 0);

        // start_i during a run is ignored
        d = dcnt2;
        run2(G_AND, TT_AND, 4'b0000, 1'b1, 1);
        repeat (3) @(negedge clk);
        st2 = 1'b1;
        @(negedge clk);
        st2 = 1'b0;
        wait_q(0, 40);
        repeat (20) @(negedge clk);
        chk("start_ignored_one_done", dcnt2 - d, 1);

        // Asynchronous reset mid-CHECK (vector 1)
        d = dcnt2;
        run2(G_AND, TT_NAND, 4'b0000, 1'b0, 0);
        repeat (5) @(negedge clk);
        chk("pre_rst_ab", {a2, b2}, 2'b01);
        chk("pre_rst_mask", m2, 4'b0001);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ab", {a2, b2}, 0);
        chk("midrst_busy", busy2, 0);
        chk("midrst_mask", m2, 0);
        chk("midrst_pass", pass2, 0);
        chk("midrst_done", done2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_idle", busy2, 0);
        chk("post_rst_no_done", dcnt2 - d, 0);

        // SETTLE_CYCLES=0: single XOR run, done 5 edges in
        g0 = G_XOR; tr0 = TT_XOR; st0 = 1'b1;
        e.mask = 4'b0000; e.pass = 1'b1; e.cyc = cyc + 5;
        q0.push_back(e);
        @(negedge clk);
        st0 = 1'b0; tr0 = 4'hF;
        chk("busy0_after_start", busy0, 1);
        wait_q(1, 20);
        chk("pass0_held", pass0, 1);

        // SETTLE_CYCLES=0: mismatches on vectors 0 and 3
        g0 = G_TIE1; tr0 = TT_XOR; st0 = 1'b1;
        e.mask = 4'b1001; e.pass = 1'b0; e.cyc = cyc + 5;
        q0.push_back(e);
        @(negedge clk);
        st0 = 1'b0;
        wait_q(1, 20);
        chk("mask0_held", m0, 4'b1001);

        // Held start: three back-to-back runs, done every 5 cycles
        g0 = G_XOR; tr0 = TT_XOR;
        d = dcnt0;
        c = cyc;
        st0 = 1'b1;
        for (int r = 0; r < 3; r++) begin
            e.mask = 4'b0000; e.pass = 1'b1; e.cyc = c + 5 + 5 * r;
            q0.push_back(e);
        end
        repeat (15) @(negedge clk);
        st0 = 1'b0;
        wait_q(1, 20);
        repeat (10) @(negedge clk);
        chk("b2b_done_count", dcnt0 - d, 3);
        chk("b2b_idle_after", busy0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
